img_mem_arbiter: RTL

//  Shares the single-port 8-bit image memory between the CPU MEM stage (lb/sb) and the VGA scan-out.

---
 rtl/img_arb_pkg.sv | 13 +
 rtl/pix_fifo.sv | 52 +++++
 rtl/img_mem_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/img_arb_pkg.sv
// Shared types and constants for the image memory arbiter.
package img_arb_pkg;

    localparam int unsigned PIX_W = 8;

    // Owner of the memory port in the previous cycle
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_e;

endpackage

// File: rtl/pix_fifo.sv
// Synchronous pixel prefetch FIFO with flush; flush has priority over push/pop.
module pix_fifo
    import img_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LVL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout,
    output logic [LVL_W-1:0] level,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & ((level_q != LVL_W'(DEPTH)) | do_pop);
    assign dout    = empty ? '0 : mem_q[rd_q];

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_W'(1);
            if (do_pop)  rd_q <= rd_q + PTR_W'(1);
            level_q <= level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    // Pixel storage, contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/img_mem_arbiter.sv
// Arbitrates the single-port image memory between CPU byte accesses and
// linear VGA pixel prefetch. Optional statistics outputs: ARB_STATS_EN.
module img_mem_arbiter
    import img_arb_pkg::*;
#(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned FRAME_BASE    = 0,
    parameter int unsigned FRAME_PIXELS  = 16384,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned LOW_WATER     = 4,
    parameter int unsigned MAX_CPU_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [PIX_W-1:0]  cpu_wdata,
    output logic              cpu_stall,
    output logic [PIX_W-1:0]  cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              frame_sync,
    input  logic              pix_pop,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              underflow,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_din,
    input  logic [PIX_W-1:0]  mem_dout
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [15:0]       underflow_cnt
`endif
);

    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W   = LVL_W + 1;
    localparam int unsigned SCAN_W  = $clog2(FRAME_PIXELS);
    localparam int unsigned BURST_W = $clog2(MAX_CPU_BURST + 1);

    owner_e              state_q;
    owner_e              state_d;
    logic [LVL_W-1:0]    level;
    logic                fifo_empty;
    logic                inflight;
    logic [OCC_W-1:0]    occ;
    logic                room;
    logic                urgent;
    logic                vga_grant;
    logic                cpu_grant;
    logic [SCAN_W-1:0]   scan_q;
    logic [BURST_W-1:0]  burst_q;
    logic                load_q;
    logic                underflow_q;
    logic                uf_event;

    // A VGA grant last cycle means its read data lands in the FIFO this cycle
    assign inflight = (state_q == OWN_VGA);
    assign occ      = OCC_W'(level) + OCC_W'(inflight);
    assign room     = (occ < OCC_W'(FIFO_DEPTH));
    assign urgent   = (occ < OCC_W'(LOW_WATER));

    // VGA wins when urgent, uncontested, or the CPU has used up its burst
    assign vga_grant = ~rst & room & ~frame_sync &
                       (urgent | ~cpu_req | (burst_q == BURST_W'(MAX_CPU_BURST)));
    assign cpu_grant = ~rst & cpu_req & ~vga_grant;
    assign cpu_stall = cpu_req & ~cpu_grant;

    assign uf_event   = pix_pop & fifo_empty & ~frame_sync;
    assign underflow  = underflow_q;
    assign pix_valid  = ~fifo_empty;
    assign cpu_rvalid = (state_q == OWN_CPU) & load_q;
    assign cpu_rdata  = cpu_rvalid ? mem_dout : '0;

    // Owner register
    always_ff @(posedge clk) begin
        if (rst) state_q <= OWN_IDLE;
        else     state_q <= state_d;
    end

    // Next owner and memory port drive
    always_comb begin
        state_d  = OWN_IDLE;
        mem_addr = '0;
        mem_we   = 1'b0;
        mem_din  = '0;
        if (vga_grant) begin
            state_d  = OWN_VGA;
            mem_addr = ADDR_W'(FRAME_BASE) + ADDR_W'(scan_q);
        end else if (cpu_grant) begin
            state_d  = OWN_CPU;
            mem_addr = cpu_addr;
            mem_we   = cpu_we;
            mem_din  = cpu_we ? cpu_wdata : '0;
        end
    end

    // Scan position, CPU burst length, load tracking and underflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q      <= '0;
            burst_q     <= '0;
            load_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (frame_sync) begin
                scan_q <= '0;
            end else if (vga_grant) begin
                scan_q <= (scan_q == SCAN_W'(FRAME_PIXELS - 1)) ? '0 : scan_q + SCAN_W'(1);
            end
            if (state_d != OWN_CPU) begin
                burst_q <= '0;
            end else if (room && (burst_q != BURST_W'(MAX_CPU_BURST))) begin
                burst_q <= burst_q + BURST_W'(1);
            end
            load_q      <= cpu_grant & ~cpu_we;
            underflow_q <= uf_event;
        end
    end

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pix_pop),
        .flush (frame_sync),
        .din   (mem_dout),
        .dout  (pix_data),
        .level (level),
        .empty (fifo_empty)
    );

`ifdef ARB_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] uf_cnt_q;

    assign stall_cnt     = stall_cnt_q;
    assign underflow_cnt = uf_cnt_q;

    // Stall-cycle and saturating underflow counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            uf_cnt_q    <= '0;
        end else begin
            if (cpu_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (uf_event && (uf_cnt_q != 16'hFFFF)) uf_cnt_q <= uf_cnt_q + 16'd1;
        end
    end
`endif

endmodule
